// File: rtl/pipemem_pkg.sv
// Shared MEM/WB pipeline definitions: FSM encoding, datapath widths,
// the MEM/WB payload struct and the bubble/reset values for its fields.
package pipemem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // MEM/WB register payload
  typedef struct packed {
    logic              wwreg;
    logic              wm2reg;
    logic [WORD_W-1:0] wmo;
    logic [WORD_W-1:0] walu;
    logic [REG_W-1:0]  wrn;
  } wb_t;

  // A bubble only kills the write-back controls; data fields hold.
  localparam logic BUBBLE_WWREG  = 1'b0;
  localparam logic BUBBLE_WM2REG = 1'b0;
  localparam wb_t  WB_RESET      = '0;

endpackage

// File: rtl/pipemem_if.sv
// Data-memory req/ack bus.
//   dmem_req/we/addr/wdata : request side, driven by the MEM stage
//   dmem_rdata/ack         : response side, driven by the memory
// master = MEM stage, slave = memory.
interface pipemem_if;
  import pipemem_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [WORD_W-1:0] dmem_addr;
  logic [WORD_W-1:0] dmem_wdata;
  logic [WORD_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/pipemem_stage_pipemwreg.sv
// MEM/WB pipeline register (module pipemwreg).
//   clk, clrn : clock, async active-high clear
//   bubble    : load a bubble (clear write-back controls, hold data fields)
//   d / q     : next / current MEM/WB payload
module pipemwreg
  import pipemem_pkg::*;
(
  input  logic clk,
  input  logic clrn,
  input  logic bubble,
  input  wb_t  d,
  output wb_t  q
);

  // Load d every cycle unless a bubble is requested
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      q <= WB_RESET;
    end else if (bubble) begin
      q.wwreg  <= BUBBLE_WWREG;
      q.wm2reg <= BUBBLE_WM2REG;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipemem_stage.sv
// Memory-access stage plus MEM/WB register.
//   clk, clrn                    : clock, async active-high reset
//   mwreg/mm2reg/mwmem/malu/mb/mrn : registered MEM-stage controls and data
//   dmem                         : req/ack data-memory bus (master side)
//   mstall                       : combinational stall to upstream stages
//   merr                         : sticky memory-timeout flag
//   wwreg/wm2reg/wmo/walu/wrn    : WB-stage outputs
module pipemem_stage
  import pipemem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic              mwmem,
  input  logic [WORD_W-1:0] malu,
  input  logic [WORD_W-1:0] mb,
  input  logic [REG_W-1:0]  mrn,
  pipemem_if.master         dmem,
  output logic              mstall,
  output logic              merr,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [WORD_W-1:0] wmo,
  output logic [WORD_W-1:0] walu,
  output logic [REG_W-1:0]  wrn
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               memop;
  logic               expired;
  logic               stall_c;
  logic               start_c;
  logic               done_c;
  logic               timeout_c;
  logic               bubble_c;
  wb_t                wb_d, wb_q;

  assign memop = mm2reg | mwmem;

  // cnt_q counts no-ack BUSY cycles; reaching TIMEOUT means TIMEOUT
  // cycles went by unanswered, so this cycle force-completes the access.
  assign expired = (cnt_q == CNT_W'(TIMEOUT));

  // Next-state, counter and control decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_c   = 1'b0;
    start_c   = 1'b0;
    done_c    = 1'b0;
    timeout_c = 1'b0;
    bubble_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop) begin
          stall_c  = 1'b1;
          start_c  = 1'b1;
          bubble_c = 1'b1;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (dmem.dmem_ack) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end else if (expired) begin
          done_c    = 1'b1;
          timeout_c = 1'b1;
          state_d   = IDLE;
        end else begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-back payload; store wins over load, so a store never returns data
  always_comb begin
    wb_d        = WB_RESET;
    wb_d.wwreg  = mwreg;
    wb_d.wm2reg = mm2reg & ~mwmem;
    wb_d.walu   = malu;
    wb_d.wrn    = mrn;
    if ((state_q == BUSY) && dmem.dmem_ack && mm2reg && !mwmem) begin
      wb_d.wmo = dmem.dmem_rdata;
    end
  end

  // Stall drops the moment reset is asserted, not at the next edge
  assign mstall = stall_c & ~clrn;

  // State and wait counter
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus request registers, latched once on IDLE->BUSY
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
    end else if (start_c) begin
      dmem.dmem_req   <= 1'b1;
      dmem.dmem_we    <= mwmem;
      dmem.dmem_addr  <= malu;
      dmem.dmem_wdata <= mb;
    end else if (done_c) begin
      dmem.dmem_req   <= 1'b0;
    end
  end

  // Sticky timeout flag
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      merr <= 1'b0;
    end else if (timeout_c) begin
      merr <= 1'b1;
    end
  end

  pipemwreg u_pipemwreg (
    .clk    (clk),
    .clrn   (clrn),
    .bubble (bubble_c),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign wwreg  = wb_q.wwreg;
  assign wm2reg = wb_q.wm2reg;
  assign wmo    = wb_q.wmo;
  assign walu   = wb_q.walu;
  assign wrn    = wb_q.wrn;

endmodule

// File: tb/tb_pipemem_stage.sv
// Self-checking bench for pipemem_stage: directed cases followed by random
// ALU/load/store traffic against a transaction-level reference model.
module tb_pipemem_stage;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 8;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        clrn;
  logic        mwreg, mm2reg, mwmem;
  logic [31:0] malu, mb;
  logic [4:0]  mrn;
  logic        mstall, merr, wwreg, wm2reg;
  logic [31:0] wmo, walu;
  logic [4:0]  wrn;

  pipemem_if bus ();

  pipemem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .clrn   (clrn),
    .mwreg  (mwreg),
    .mm2reg (mm2reg),
    .mwmem  (mwmem),
    .malu   (malu),
    .mb     (mb),
    .mrn    (mrn),
    .dmem   (bus),
    .mstall (mstall),
    .merr   (merr),
    .wwreg  (wwreg),
    .wm2reg (wm2reg),
    .wmo    (wmo),
    .walu   (walu),
    .wrn    (wrn)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of the architectural WB state
  logic        m_wwreg, m_wm2reg, m_merr;
  logic [31:0] m_wmo, m_walu;
  logic [4:0]  m_wrn;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wwreg = 1'b0; m_wm2reg = 1'b0; m_merr = 1'b0;
    m_wmo = 32'h0; m_walu = 32'h0; m_wrn = 5'h0;
  endtask

  task automatic check_wb();
    chk("wwreg",  32'(wwreg),  32'(m_wwreg));
    chk("wm2reg", 32'(wm2reg), 32'(m_wm2reg));
    chk("wmo",    wmo,         m_wmo);
    chk("walu",   walu,        m_walu);
    chk("wrn",    32'(wrn),    32'(m_wrn));
    chk("merr",   32'(merr),   32'(m_merr));
  endtask

  // One instruction through MEM. Called at a negedge, returns at a negedge.
  // ack_delay = BUSY cycles without ack before the ack pulse; NEVER = no ack.
  task automatic run_op(input logic wreg, input logic m2reg, input logic wmem,
                        input logic [31:0] alu, input logic [31:0] b,
                        input logic [4:0] rn, input int ack_delay,
                        input logic [31:0] rdata, input logic spur);
    logic memop;
    logic timed_out;
    logic done;
    int   stalls;
    int   n_wait;
    memop     = m2reg | wmem;
    timed_out = memop && (ack_delay > int'(TIMEOUT));
    mwreg = wreg; mm2reg = m2reg; mwmem = wmem;
    malu = alu; mb = b; mrn = rn;
    bus.dmem_ack   = spur;
    bus.dmem_rdata = rdata;
    #1;
    chk("idle_stall", 32'(mstall), 32'(memop));
    chk("idle_req", 32'(bus.dmem_req), 32'(1'b0));
    @(posedge clk);
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    if (!memop) begin
      m_wwreg = wreg; m_wm2reg = 1'b0; m_wmo = 32'h0;
      m_walu = alu; m_wrn = rn;
      check_wb();
    end else begin
      stalls = 1;
      done   = 1'b0;
      for (int k = 0; k <= int'(TIMEOUT) + 1 && !done; k++) begin
        chk("req",     32'(bus.dmem_req), 32'(1'b1));
        chk("we",      32'(bus.dmem_we),  32'(wmem));
        chk("addr",    bus.dmem_addr,     alu);
        chk("wdata",   bus.dmem_wdata,    b);
        chk("bub_wwreg",  32'(wwreg),  32'(1'b0));
        chk("bub_wm2reg", 32'(wm2reg), 32'(1'b0));
        chk("hold_walu",  walu, m_walu);
        chk("hold_wrn",   32'(wrn), 32'(m_wrn));
        if (!timed_out && k == ack_delay) begin
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = rdata;
          done = 1'b1;
        end else begin
          bus.dmem_rdata = $urandom;
          if (timed_out && k == int'(TIMEOUT)) done = 1'b1;
        end
        #1;
        if (mstall) stalls++;
        chk("busy_stall", 32'(mstall), 32'(!done));
        @(posedge clk);
        @(negedge clk);
        bus.dmem_ack = 1'b0;
      end
      chk("complete", 32'(done), 32'(1'b1));
      n_wait = timed_out ? int'(TIMEOUT) : ack_delay;
      chk("stall_len", 32'(stalls), 32'(1 + n_wait));
      m_wwreg  = wreg;
      m_wm2reg = m2reg & ~wmem;
      m_wmo    = (!timed_out && m2reg && !wmem) ? rdata : 32'h0;
      m_walu   = alu;
      m_wrn    = rn;
      if (timed_out) m_merr = 1'b1;
      chk("req_drop", 32'(bus.dmem_req), 32'(1'b0));
      check_wb();
    end
  endtask

  task automatic run_random(input int n);
    int kind;
    int dly;
    for (int i = 0; i < n; i++) begin
      kind = int'($urandom_range(0, 3));
      dly  = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 5));
      run_op(1'($urandom), 1'(kind == 1 || kind == 3), 1'(kind == 2 || kind == 3),
             $urandom, $urandom, 5'($urandom), dly, $urandom,
             1'($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clrn = 1'b1;
    mwreg = 1'b0; mm2reg = 1'b0; mwmem = 1'b0;
    malu = 32'h0; mb = 32'h0; mrn = 5'h0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req",   32'(bus.dmem_req), 32'(1'b0));
    chk("rst_stall", 32'(mstall), 32'(1'b0));
    check_wb();
    clrn = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 5'd3, 0, 32'h0, 1'b0);
    run_op(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd7, 0, 32'hDEAD_BEEF, 1'b0);
    run_op(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 5'd9, 3, 32'h7777_0000, 1'b0);
    run_op(1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 5'd12, 0, 32'hCAFE_F00D, 1'b1);
    run_op(1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'hABCD_0001, 5'd14, 1, 32'h1111_2222, 1'b0);
    run_op(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd4, NEVER, 32'h5555_AAAA, 1'b0);

    run_random(40);

    // Reset in the middle of a load
    mwreg = 1'b1; mm2reg = 1'b1; mwmem = 1'b0;
    malu = 32'h0000_0800; mb = 32'h0; mrn = 5'd21;
    @(posedge clk);
    @(negedge clk);
    chk("mid_req", 32'(bus.dmem_req), 32'(1'b1));
    #2 clrn = 1'b1;
    #1;
    model_reset();
    chk("arst_req",   32'(bus.dmem_req), 32'(1'b0));
    chk("arst_we",    32'(bus.dmem_we), 32'(1'b0));
    chk("arst_addr",  bus.dmem_addr, 32'h0);
    chk("arst_stall", 32'(mstall), 32'(1'b0));
    check_wb();
    mwreg = 1'b0; mm2reg = 1'b0; mwmem = 1'b0;
    malu = 32'h0; mb = 32'h0; mrn = 5'h0;
    @(negedge clk);
    clrn = 1'b0;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    chk("late_ack_req",   32'(bus.dmem_req), 32'(1'b0));
    chk("late_ack_stall", 32'(mstall), 32'(1'b0));
    check_wb();

    run_random(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
